// File: rtl/cnn_fmap_window.sv
// Sliding KX x KY window generator for the CNN kernel stage: raster-order pixels in,
// packed windows out, using KY-1 line buffers and a KY x KX window register array.
module cnn_fmap_window #(
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_soft_reset,
    input  logic                       i_in_valid,
    input  logic [I_F_BW-1:0]          i_in_pixel,
    output logic                       o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]    o_ot_fmap,
    output logic                       o_ot_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KY - 1);

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [I_F_BW-1:0]   lb      [KY-1][IMG_W];
    logic [I_F_BW-1:0]   win     [KY][KX];
    logic [I_F_BW-1:0]   new_col [KY];
    logic [I_F_BW-1:0]   nxt_win [KY][KX];
    logic [KX*KY*I_F_BW-1:0] nxt_fmap;

    logic accept;
    logic win_done;
    logic frame_end;

    // Soft reset drops a coincident pixel, so it never counts as accepted.
    assign accept    = i_in_valid && !i_soft_reset;
    assign win_done  = (row >= ROW_WIN) && (col >= COL_WIN);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    // lb[0] holds the oldest buffered row, lb[KY-2] the row just above the current one.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
        for (int y = 0; y < KY - 1; y++) begin
            new_col[y] = lb[y][col];
        end
        new_col[KY-1] = i_in_pixel;
    end

    always_comb begin
        for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX - 1; x++) begin
                nxt_win[y][x] = win[y][x+1];
            end
            nxt_win[y][KX-1] = new_col[y];
        end
    end

    always_comb begin
        nxt_fmap = '0;
        for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX; x++) begin
                nxt_fmap[(y*KX + x)*I_F_BW +: I_F_BW] = nxt_win[y][x];
            end
        end
    end

    // NOTE: line buffers are plain storage with no reset; stale entries never reach a valid window.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < KY - 2; k++) begin
                lb[k][col] <= lb[k+1][col];
            end
            lb[KY-2][col] <= i_in_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            col        <= '0;
            row        <= '0;
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            o_ot_fmap  <= '0;
            for (int y = 0; y < KY; y++) begin
                for (int x = 0; x < KX; x++) begin
                    win[y][x] <= '0;
                end
            end
        end else if (i_soft_reset) begin
            col        <= '0;
            row        <= '0;
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            o_ot_fmap  <= '0;
            for (int y = 0; y < KY; y++) begin
                for (int x = 0; x < KX; x++) begin
                    win[y][x] <= '0;
                end
            end
        end else begin
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            if (accept) begin
                win <= nxt_win;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (win_done) begin
                    o_ot_valid <= 1'b1;
                    o_ot_last  <= frame_end;
                    o_ot_fmap  <= nxt_fmap;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_fmap_window.sv
// Scoreboard bench for cnn_fmap_window on a 5x4 image with a 3x3 window.
module tb_cnn_fmap_window;

    localparam int KX = 3, KY = 3, BW = 8, W = 5, H = 4;
    localparam int FW = KX*KY*BW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_soft_reset;
    logic          i_in_valid;
    logic [BW-1:0] i_in_pixel;
    logic          o_ot_valid;
    logic [FW-1:0] o_ot_fmap;
    logic          o_ot_last;

    typedef struct {
        logic [FW-1:0] fmap;
        logic          last;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_win = 0;
    int            r = 0;
    int            c = 0;
    int            cur_base = 0;
    bit            skip_hold = 1'b0;
    logic [FW-1:0] prev_fmap = '0;

    cnn_fmap_window #(.KX(KX), .KY(KY), .I_F_BW(BW), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_soft_reset (i_soft_reset),
        .i_in_valid   (i_in_valid),
        .i_in_pixel   (i_in_pixel),
        .o_ot_valid   (o_ot_valid),
        .o_ot_fmap    (o_ot_fmap),
        .o_ot_last    (o_ot_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_win(input int base, input int pr, input int pc);
        logic [FW-1:0] f;
        f = '0;
        for (int y = 0; y < KY; y++)
            for (int x = 0; x < KX; x++)
                f[(y*KX + x)*BW +: BW] = BW'(base + (pr - KY + 1 + y)*W + (pc - KX + 1 + x) + 1);
        return f;
    endfunction

    // One clock of stimulus; returns 1 time unit after the edge and checks the strobes.
    task automatic send(input bit v, input logic [BW-1:0] px, input bit srst);
        bit win_exp;
        bit last_exp;
        win_exp  = v && !srst && r >= KY - 1 && c >= KX - 1;
        last_exp = win_exp && r == H - 1 && c == W - 1;
        if (win_exp) q.push_back('{exp_win(cur_base, r, c), last_exp});
        i_in_valid   = v;
        i_in_pixel   = px;
        i_soft_reset = srst;
        @(posedge clk);
        #1;
        i_in_valid   = 1'b0;
        i_soft_reset = 1'b0;
        if (srst) begin
            r = 0;
            c = 0;
            skip_hold = 1'b1;
            check("srst_fmap", o_ot_fmap, '0);
        end else if (v) begin
            if (c == W - 1) begin
                c = 0;
                r = (r == H - 1) ? 0 : r + 1;
            end else begin
                c++;
            end
        end
        check("valid", FW'(o_ot_valid), FW'(win_exp));
        check("last", FW'(o_ot_last), FW'(last_exp));
    endtask

    task automatic send_pixels(input int base, input int n, input bit bubbles);
        cur_base = base;
        for (int i = 0; i < n; i++) begin
            if (bubbles) while ($urandom_range(0, 1) == 1) send(1'b0, 8'h00, 1'b0);
            send(1'b1, BW'(base + i + 1), 1'b0);
        end
    endtask

    task automatic idle_and_count(input int start, input int expect_wins, input string tag);
        for (int i = 0; i < 3; i++) send(1'b0, 8'h00, 1'b0);
        check({tag, "_wins"}, FW'(n_win - start), FW'(expect_wins));
        check({tag, "_q_empty"}, FW'(q.size()), '0);
    endtask

    // Scoreboard side: pop on every window, and check fmap holds while valid is low.
    always @(negedge clk) begin
        if (o_ot_valid) begin
            n_win++;
            if (q.size() == 0) begin
                check("unexpected_win", '1, '0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("win_fmap", o_ot_fmap, e.fmap);
                check("win_last", FW'(o_ot_last), FW'(e.last));
            end
        end else if (!skip_hold) begin
            check("fmap_hold", o_ot_fmap, prev_fmap);
        end
        skip_hold = 1'b0;
        prev_fmap = o_ot_fmap;
    end

    initial begin
        int start;
        reset_n      = 1'b0;
        i_soft_reset = 1'b0;
        i_in_valid   = 1'b0;
        i_in_pixel   = '0;
        #2;
        check("rst_valid", FW'(o_ot_valid), '0);
        check("rst_last", FW'(o_ot_last), '0);
        check("rst_fmap", o_ot_fmap, '0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, no bubbles.
        start = n_win;
        send_pixels(0, W*H, 1'b0);
        idle_and_count(start, 6, "basic");

        // Same frame with random bubbles.
        start = n_win;
        send_pixels(0, W*H, 1'b1);
        idle_and_count(start, 6, "bubbles");

        // Two frames back to back, second offset by 100.
        start = n_win;
        send_pixels(0, W*H, 1'b0);
        send_pixels(100, W*H, 1'b0);
        idle_and_count(start, 12, "b2b");

        // Soft reset after 9 pixels, then a fresh frame.
        send_pixels(0, 9, 1'b0);
        send(1'b0, 8'h00, 1'b1);
        start = n_win;
        send_pixels(0, W*H, 1'b0);
        idle_and_count(start, 6, "srst");

        // Async reset while the first window (pixel 13, mid-row) is on the outputs.
        send_pixels(0, 13, 1'b0);
        check("async_pre_valid", FW'(o_ot_valid), FW'(1));
        #2;
        reset_n   = 1'b0;
        skip_hold = 1'b1;
        #1;
        check("async_valid", FW'(o_ot_valid), '0);
        check("async_last", FW'(o_ot_last), '0);
        check("async_fmap", o_ot_fmap, '0);
        q.delete();
        r = 0;
        c = 0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        start = n_win;
        send_pixels(0, W*H, 1'b0);
        idle_and_count(start, 6, "async");

        // Soft reset collides with pixel 13: no window, counters back to (0,0).
        send_pixels(0, 12, 1'b0);
        start = n_win;
        send(1'b1, 8'd13, 1'b1);
        send(1'b0, 8'h00, 1'b0);
        check("coll_no_win", FW'(n_win - start), '0);
        start = n_win;
        send_pixels(0, W*H, 1'b0);
        idle_and_count(start, 6, "coll");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
